// File: rtl/fir_sym_folded.sv
// rtl/fir_sym_folded.sv - folded symmetric FIR: one pre-adder, one multiplier, one accumulator
module fir_sym_folded #(
    parameter int N_TAPS = 100,
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 72,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            coef_we,
    input  logic [$clog2(N_TAPS/2)-1:0]     coef_addr,
    input  logic [COEF_W-1:0]               coef_data,
    output logic                            coef_err,
    output logic                            out_valid,
    output logic [OUT_W-1:0]                out_data,
    output logic                            out_sat,
    output logic                            busy
);
    localparam int HALF = N_TAPS / 2;
    localparam int KW   = $clog2(HALF);
    localparam int IW   = $clog2(N_TAPS);
    localparam int PW   = DATA_W + 1;
    localparam int MW   = PW + COEF_W;
    localparam int RW   = ACC_W + 1;

    localparam logic [KW-1:0] K_LAST  = KW'(HALF - 1);
    localparam logic [KW:0]   HALF_W  = (KW + 1)'(HALF);
    localparam logic [IW-1:0] TOP_IDX = IW'(N_TAPS - 1);
    localparam logic [RW-1:0] RND     = ({{(RW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         d_q [N_TAPS];
    logic [DATA_W-1:0]         d_d [N_TAPS];
    logic [COEF_W-1:0]         c_q [HALF];
    logic [COEF_W-1:0]         c_d [HALF];
    logic [KW-1:0]             k_q, k_d;
    logic                      flush_q, flush_d;
    logic signed [PW-1:0]      p_q, p_d;
    logic signed [COEF_W-1:0]  ca_q, ca_d;
    logic                      a_vld_q, a_vld_d;
    logic                      b_vld_q, b_vld_d;
    logic signed [MW-1:0]      m_q, m_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sat_q, out_sat_d;
    logic                      coef_err_q, coef_err_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;

    logic signed [RW-1:0]      r;
    logic [IW-1:0]             lo_idx, hi_idx;
    logic                      accept, coef_ok;

    always_comb begin
        accept  = in_valid && in_ready_q;
        coef_ok = (state_q == S_IDLE) && ({1'b0, coef_addr} < HALF_W);
        lo_idx  = IW'(k_q);
        hi_idx  = TOP_IDX - lo_idx;
        r       = ($signed({acc_q[ACC_W-1], acc_q}) + $signed(RND)) >>> SHIFT;

        state_d     = state_q;
        d_d         = d_q;
        c_d         = c_q;
        k_d         = k_q;
        flush_d     = flush_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (coef_we && coef_ok) begin
            c_d[coef_addr] = coef_data;
        end
        coef_err_d = coef_we && !coef_ok;

        // Three-stage MAC pipeline: pre-add, multiply, accumulate
        p_d     = $signed({d_q[lo_idx][DATA_W-1], d_q[lo_idx]})
                + $signed({d_q[hi_idx][DATA_W-1], d_q[hi_idx]});
        ca_d    = c_q[k_q];
        a_vld_d = (state_q == S_MAC);
        m_d     = p_q * ca_q;
        b_vld_d = a_vld_q;
        acc_d   = b_vld_q ? acc_q + {{(ACC_W-MW){m_q[MW-1]}}, m_q} : acc_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    for (int i = N_TAPS - 1; i > 0; i--) begin
                        d_d[i] = d_q[i-1];
                    end
                    d_d[0]  = in_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == K_LAST) begin
                    flush_d = 1'b0;
                    state_d = S_FLUSH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = S_OUT;
                end
            end
            default: begin
                out_valid_d = 1'b1;
                if (r > OMAX) begin
                    out_data_d = OMAX[OUT_W-1:0];
                    out_sat_d  = 1'b1;
                end else if (r < OMIN) begin
                    out_data_d = OMIN[OUT_W-1:0];
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = r[OUT_W-1:0];
                    out_sat_d  = 1'b0;
                end
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            d_q         <= '{default: '0};
            c_q         <= '{default: '0};
            k_q         <= '0;
            flush_q     <= 1'b0;
            p_q         <= '0;
            ca_q        <= '0;
            a_vld_q     <= 1'b0;
            b_vld_q     <= 1'b0;
            m_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            coef_err_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            c_q         <= c_d;
            k_q         <= k_d;
            flush_q     <= flush_d;
            p_q         <= p_d;
            ca_q        <= ca_d;
            a_vld_q     <= a_vld_d;
            b_vld_q     <= b_vld_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            coef_err_q  <= coef_err_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = !in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign coef_err  = coef_err_q;
endmodule

// File: tb/tb_fir_sym_folded.sv
// tb/tb_fir_sym_folded.sv - directed bench for fir_sym_folded (three parameterisations)
module tb_fir_sym_folded;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, coef_we;
    logic [31:0] in_data, coef_data;
    logic [1:0]  coef_addr;
    int          sel;
    int          errors = 0;
    int          checks = 0;

    logic        a_ready, a_busy, a_valid, a_sat, a_err;
    logic [31:0] a_data;
    logic        r_ready, r_busy, r_valid, r_sat, r_err;
    logic [31:0] r_data;
    logic        s_ready, s_busy, s_valid, s_sat, s_err;
    logic [15:0] s_data;

    logic               o_ready, o_busy, o_valid, o_sat, o_err;
    logic signed [31:0] o_data;

    logic signed [31:0] xs [16];
    logic signed [31:0] ys [16];
    int                 yt [16];

    fir_sym_folded #(.N_TAPS(8), .SHIFT(0), .OUT_W(32)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 0)), .in_ready(a_ready),
        .in_data(in_data), .coef_we(coef_we && (sel == 0)), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(a_err), .out_valid(a_valid), .out_data(a_data),
        .out_sat(a_sat), .busy(a_busy));

    fir_sym_folded #(.N_TAPS(8), .SHIFT(2), .OUT_W(32)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 1)), .in_ready(r_ready),
        .in_data(in_data), .coef_we(coef_we && (sel == 1)), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(r_err), .out_valid(r_valid), .out_data(r_data),
        .out_sat(r_sat), .busy(r_busy));

    fir_sym_folded #(.N_TAPS(6), .SHIFT(0), .OUT_W(16)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 2)), .in_ready(s_ready),
        .in_data(in_data), .coef_we(coef_we && (sel == 2)), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(s_err), .out_valid(s_valid), .out_data(s_data),
        .out_sat(s_sat), .busy(s_busy));

    always_comb begin
        o_ready = a_ready; o_busy = a_busy; o_valid = a_valid; o_sat = a_sat; o_err = a_err;
        o_data  = a_data;
        if (sel == 1) begin
            o_ready = r_ready; o_busy = r_busy; o_valid = r_valid; o_sat = r_sat; o_err = r_err;
            o_data  = r_data;
        end else if (sel == 2) begin
            o_ready = s_ready; o_busy = s_busy; o_valid = s_valid; o_sat = s_sat; o_err = s_err;
            o_data  = {{16{s_data[15]}}, s_data};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 1'b0; coef_we = 1'b0; in_data = '0; coef_addr = '0; coef_data = '0;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we = 1'b1; coef_addr = 2'(a); coef_data = v;
        tick;
        coef_we = 1'b0;
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        write_coef(0, c0); write_coef(1, c1); write_coef(2, c2); write_coef(3, c3);
    endtask

    task automatic run_sample(input int x, output logic signed [31:0] y, output int lat);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin tick; n++; end
        in_valid = 1'b1; in_data = x;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin tick; lat++; end
        y = o_valid ? o_data : 'x;
    endtask

    task automatic run_stream(input int n_in, input int n_out);
        int  idx, got, cyc;
        bit  taken;
        idx = 0; got = 0; cyc = 0;
        for (int i = 0; i < 16; i++) begin ys[i] = 'x; yt[i] = 0; end
        while (got < n_out && cyc < 500) begin
            in_valid = (idx < n_in);
            in_data  = (idx < 16) ? xs[idx] : '0;
            taken    = o_ready && in_valid;
            tick; cyc++;
            if (taken) idx++;
            if (o_valid) begin ys[got] = o_data; yt[got] = cyc; got++; end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic signed [31:0] y;
        int lat;
        sel = 0;
        do_reset;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", o_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", o_valid); end
        checks++; if (o_data !== 0) begin errors++; $display("FAIL rst_out_data got %0d want 0", o_data); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %b want 0", o_sat); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_coef_err got %b want 0", o_err); end
        run_sample(7, y, lat);
        checks++; if (y !== 0) begin errors++; $display("FAIL zero_coef_out got %0d want 0", y); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL latency got %0d want 7", lat); end
    endtask

    task automatic test_impulse;
        int exp_y [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
        sel = 0;
        do_reset;
        write_coef(0, 1);
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL good_write_err got %b want 0", o_err); end
        write_coef(1, 2); write_coef(2, 3); write_coef(3, 4);
        xs[0] = 1;
        for (int i = 1; i < 9; i++) xs[i] = 0;
        run_stream(9, 9);
        for (int i = 0; i < 9; i++) begin
            checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL impulse[%0d] got %0d want %0d", i, ys[i], exp_y[i]); end
        end
        for (int i = 1; i < 9; i++) begin
            checks++; if (yt[i] - yt[i-1] !== 8) begin errors++; $display("FAIL impulse_gap[%0d] got %0d want 8", i, yt[i] - yt[i-1]); end
        end
    endtask

    task automatic test_step;
        int exp_y [10] = '{100, 300, 600, 1000, 1400, 1700, 1900, 2000, 2000, 2000};
        sel = 0;
        do_reset;
        load4(1, 2, 3, 4);
        for (int i = 0; i < 10; i++) xs[i] = 100;
        run_stream(10, 10);
        for (int i = 0; i < 10; i++) begin
            checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL step[%0d] got %0d want %0d", i, ys[i], exp_y[i]); end
        end
        checks++; if (yt[9] - yt[8] !== 8) begin errors++; $display("FAIL step_gap got %0d want 8", yt[9] - yt[8]); end
    endtask

    task automatic test_back_to_back;
        int n;
        sel = 0;
        do_reset;
        load4(1, 2, 3, 4);
        in_valid = 1'b1; in_data = 1;
        tick;
        in_data = 2;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", o_ready); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_flag got %b want 1", o_busy); end
        tick;
        coef_we = 1'b1; coef_addr = 0; coef_data = 50;
        tick;
        coef_we = 1'b0;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL busy_coef_err got %b want 1", o_err); end
        tick;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL coef_err_pulse got %b want 0", o_err); end
        n = 0;
        while (!o_valid && n < 50) begin tick; n++; end
        checks++; if (o_data !== 1 || !o_valid) begin errors++; $display("FAIL held_first got %0d valid %b want 1", o_data, o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_with_out got %b want 1", o_ready); end
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 50) begin tick; n++; end
        checks++; if (o_data !== 4 || !o_valid) begin errors++; $display("FAIL held_second got %0d valid %b want 4", o_data, o_valid); end
    endtask

    task automatic test_reset_mid_mac;
        logic signed [31:0] y;
        int lat, pulses;
        sel = 0;
        do_reset;
        load4(1, 2, 3, 4);
        in_valid = 1'b1; in_data = 7;
        tick;
        in_valid = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin tick; if (o_valid) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", o_ready); end
        load4(1, 2, 3, 4);
        run_sample(5, y, lat);
        checks++; if (y !== 5) begin errors++; $display("FAIL abort_fresh got %0d want 5", y); end
    endtask

    task automatic test_rounding;
        logic signed [31:0] y;
        int lat;
        sel = 1;
        do_reset;
        write_coef(0, 3);
        run_sample(1, y, lat);
        checks++; if (y !== 1) begin errors++; $display("FAIL round_pos got %0d want 1", y); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL round_pos_sat got %b want 0", o_sat); end
        run_sample(-2, y, lat);
        checks++; if (y !== -1) begin errors++; $display("FAIL round_neg got %0d want -1", y); end
    endtask

    task automatic test_saturation;
        logic signed [31:0] y;
        int lat;
        sel = 2;
        do_reset;
        write_coef(0, 32767);
        run_sample(32767, y, lat);
        checks++; if (y !== 32767) begin errors++; $display("FAIL sat_pos got %0d want 32767", y); end
        checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b want 1", o_sat); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL sat_latency got %0d want 6", lat); end
        run_sample(-32768, y, lat);
        checks++; if (y !== -32768) begin errors++; $display("FAIL sat_neg got %0d want -32768", y); end
        checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got %b want 1", o_sat); end
        write_coef(3, 9);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL bad_addr_err got %b want 1", o_err); end
    endtask

    initial begin
        sel = 0;
        reset = 1'b1;
        test_reset;
        test_impulse;
        test_step;
        test_back_to_back;
        test_reset_mid_mac;
        test_rounding;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
